// File: rtl/mul4_sched.sv
// Shared shift-and-add multiplier for two requesters: arbitrate, run WIDTH add/shift steps, return a tagged product.
// Optional MUL4_SCHED_RR_EN selects round-robin arbitration; fixed priority (requester 0 wins ties) otherwise.
module mul4_sched #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_i,
    input  logic [WIDTH-1:0]   a0_i,
    input  logic [WIDTH-1:0]   b0_i,
    input  logic [WIDTH-1:0]   a1_i,
    input  logic [WIDTH-1:0]   b1_i,
    output logic [1:0]         gnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               owner_o,
    output logic [2*WIDTH-1:0] p_o,
    output logic [CNT_W-1:0]   ops_o
);

    localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 win_q, win_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 owner_q, owner_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CNT_W-1:0]     ops_q, ops_d;
    logic                 win;
    logic [2*WIDTH-1:0]   a_ext;

`ifdef MUL4_SCHED_RR_EN
    logic ptr_q, ptr_d;

    // On a tie the pointer names the winner; it always points away from the last one served.
    assign win = (req_i == 2'b11) ? ptr_q : req_i[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && req_i != 2'b00) ptr_d = ~win;
    end
`else
    assign win = req_i[1] & ~req_i[0];
`endif

    assign a_ext = {{WIDTH{1'b0}}, a_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            win_q   <= 1'b0;
            gnt_q   <= 2'b00;
            owner_q <= 1'b0;
            p_q     <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            p_q     <= p_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        win_d   = win_q;
        gnt_d   = 2'b00;
        owner_d = owner_q;
        p_d     = p_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    a_d     = win ? a1_i : a0_i;
                    b_d     = win ? b1_i : b0_i;
                    acc_d   = '0;
                    step_d  = '0;
                    win_d   = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_q + (b_q[step_q] ? (a_ext << step_q) : '0);
                step_d = step_q + STEP_W'(1);
                // Result registers load with the final sum so they are valid alongside done_o.
                if (step_q == STEP_W'(WIDTH - 1)) begin
                    p_d     = acc_d;
                    owner_d = win_q;
                    ops_d   = ops_q + CNT_W'(1);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o   = gnt_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign owner_o = owner_q;
    assign p_o     = p_q;
    assign ops_o   = ops_q;

endmodule

// File: tb/tb_mul4_sched.sv
// Scoreboard bench for mul4_sched: driver predicts grants and pushes expected products, monitor checks done_o results.
module tb_mul4_sched;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
`ifdef MUL4_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req;
    logic [WIDTH-1:0]     a0, b0, a1, b1;
    logic [1:0]           gnt_o;
    logic                 busy_o, done_o, owner_o;
    logic [2*WIDTH-1:0]   p_o;
    logic [CNT_W-1:0]     ops_o;

    always #5 clk = ~clk;

    mul4_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
        .gnt_o(gnt_o), .busy_o(busy_o), .done_o(done_o),
        .owner_o(owner_o), .p_o(p_o), .ops_o(ops_o)
    );

    typedef struct {
        bit owner;
        int prod;
        int gcyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   grants   = 0;
    int   m_ops    = 0;
    bit   mptr     = 1'b0;
    bit   keep0    = 1'b0;
    bit   keep1    = 1'b0;
    bit   rand_mode = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   gnt_o,   0);
        check({tag, "_busy"},  busy_o,  0);
        check({tag, "_done"},  done_o,  0);
        check({tag, "_owner"}, owner_o, 0);
        check({tag, "_p"},     p_o,     0);
        check({tag, "_ops"},   ops_o,   0);
    endtask

    // Monitor: every done_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy_o === 1'b1) busy_cnt++;
            else if (busy_cnt != 0) begin
                check("busy_len", busy_cnt, WIDTH + 1);
                busy_cnt = 0;
            end
            if (done_o === 1'b1) begin
                if (sb.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    m_ops = (m_ops + 1) % (1 << CNT_W);
                    check("product", p_o, mon_e.prod);
                    check("owner", owner_o, mon_e.owner);
                    check("ops_count", ops_o, m_ops);
                    check("latency", cyc - mon_e.gcyc, WIDTH);
                end
            end
        end
    end

    // One driver cycle: predict and record any grant, then update requests.
    task automatic drv_step();
        bit   w;
        exp_t e;
        @(negedge clk);
        if (gnt_o !== 2'b00) begin
            if (req == 2'b11) w = RR ? mptr : 1'b0;
            else              w = req[1];
            check("gnt_winner", gnt_o, w ? 2 : 1);
            mptr   = ~w;
            e.owner = w;
            e.prod  = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
            e.gcyc  = cyc;
            sb.push_back(e);
            grants++;
            if (w) begin
                a1 = WIDTH'($urandom_range(15));
                b1 = WIDTH'($urandom_range(15));
                if (!keep1) req[1] = 1'b0;
                if (rand_mode) keep1 = 1'($urandom_range(1));
            end else begin
                a0 = WIDTH'($urandom_range(15));
                b0 = WIDTH'($urandom_range(15));
                if (!keep0) req[0] = 1'b0;
                if (rand_mode) keep0 = 1'($urandom_range(1));
            end
        end
        if (rand_mode) begin
            if (!req[0] && $urandom_range(1) == 1) begin
                a0 = WIDTH'($urandom_range(15));
                b0 = WIDTH'($urandom_range(15));
                keep0 = 1'($urandom_range(1));
                req[0] = 1'b1;
            end
            if (!req[1] && $urandom_range(1) == 1) begin
                a1 = WIDTH'($urandom_range(15));
                b1 = WIDTH'($urandom_range(15));
                keep1 = 1'($urandom_range(1));
                req[1] = 1'b1;
            end
        end
    endtask

    task automatic wait_grants(input int n, input int budget);
        int target;
        int t;
        target = grants + n;
        t = 0;
        while (grants < target && t < budget) begin
            drv_step();
            t++;
        end
        if (grants < target) check("grant_timeout", grants, target);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        req = 2'b00;
        keep0 = 1'b0;
        keep1 = 1'b0;
        while ((sb.size() != 0 || busy_o !== 1'b0) && t < budget) begin
            drv_step();
            t++;
        end
        if (sb.size() != 0 || busy_o !== 1'b0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drv_step();

        // Worst-case operands on requester 0
        a0 = 4'hF; b0 = 4'hF; req = 2'b01;
        wait_grants(1, 20);
        drain(40);
        check("hold_p_e1", p_o, 8'hE1);
        check("hold_ops_1", ops_o, 1);

        // Requester 1 alone; operand change after grant must not matter
        a1 = 4'h7; b1 = 4'h6; req = 2'b10;
        wait_grants(1, 20);
        a1 = 4'h3;
        drain(40);
        check("hold_p_2a", p_o, 8'h2A);
        check("hold_owner_1", owner_o, 1);

        // Continuous tie
        a0 = 4'h5; b0 = 4'h3; a1 = 4'h9; b1 = 4'hB;
        keep0 = 1'b1; keep1 = 1'b1; req = 2'b11;
        wait_grants(8, 100);
        drain(40);

        // Zero operand still takes full latency
        a0 = 4'h0; b0 = 4'h9; req = 2'b01;
        wait_grants(1, 20);
        drain(40);
        check("hold_p_zero", p_o, 0);

        // Reset during the second CALC cycle
        a0 = 4'h3; b0 = 4'h5; req = 2'b01;
        wait_grants(1, 20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        sb.delete();
        m_ops = 0;
        mptr = 1'b0;
        req = 2'b00;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) drv_step();
        a1 = 4'hC; b1 = 4'hD; req = 2'b10;
        wait_grants(1, 20);
        drain(40);
        check("post_reset_ops", ops_o, 1);
        check("post_reset_p", p_o, 8'h9C);

        // Random traffic up to 255 completed operations, then one more to wrap
        rand_mode = 1'b1;
        wait_grants(254, 254 * 20);
        rand_mode = 1'b0;
        drain(60);
        check("ops_255", ops_o, 8'hFF);
        a0 = WIDTH'($urandom_range(15)); b0 = WIDTH'($urandom_range(15)); req = 2'b01;
        wait_grants(1, 20);
        drain(40);
        check("ops_wrap", ops_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
